// File: rtl/bit_unstuffer_deser_if.sv
// Receive-side bus between the NRZI decoder, the bit unstuffer/deserialiser and the PID parser.
// The master drives the serial bit stream and the slave returns assembled words and status.
interface bit_unstuffer_deser_if #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned NB_W = $clog2(OUT_W + 1);

  logic             in_valid;
  logic             in_bit;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [NB_W-1:0]  out_nbits;
  logic             out_eop;
  logic             stuff_err;
  logic [CNT_W-1:0] bit_count;
  logic             busy;

  modport master (
    output in_valid, in_bit,
    input  out_valid, out_data, out_nbits, out_eop, stuff_err, bit_count, busy
  );

  modport slave (
    input  in_valid, in_bit,
    output out_valid, out_data, out_nbits, out_eop, stuff_err, bit_count, busy
  );
endinterface

// File: rtl/bit_unstuffer_deser.sv
// Removes stuffed zeros after RUN_LEN ones and packs the destuffed bits LSB-first
// into OUT_W-bit words, with end-of-packet flush of any partial word.
module bit_unstuffer_deser #(
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned RUN_LEN   = 6,
  parameter int unsigned CHECK_ERR = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  bit_unstuffer_deser_if.slave  bus
);
  localparam int unsigned NB_W  = $clog2(OUT_W + 1);
  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
  localparam logic [NB_W-1:0]  FULL     = NB_W'(OUT_W);
  localparam logic [NB_W-1:0]  LAST_POS = NB_W'(OUT_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [RUN_W-1:0] run_q, run_n;
  logic [NB_W-1:0]  fill_q, fill_n;
  logic [OUT_W-1:0] shreg_q, shreg_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ov_q, ov_n;
  logic [OUT_W-1:0] od_q, od_n;
  logic [NB_W-1:0]  on_q, on_n;
  logic             eop_q, eop_n;
  logic             err_q, err_n;
  logic             busy_q;
  logic             do_proc;
  logic [OUT_W-1:0] word_n;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      fill_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      on_q    <= '0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      run_q   <= run_n;
      fill_q  <= fill_n;
      shreg_q <= shreg_n;
      cnt_q   <= cnt_n;
      ov_q    <= ov_n;
      od_q    <= od_n;
      on_q    <= on_n;
      eop_q   <= eop_n;
      err_q   <= err_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  // Next-state, bit processing and output decode
  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    fill_n  = fill_q;
    shreg_n = shreg_q;
    cnt_n   = cnt_q;
    ov_n    = 1'b0;
    od_n    = '0;
    on_n    = '0;
    eop_n   = 1'b0;
    err_n   = 1'b0;
    do_proc = 1'b0;
    word_n  = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = ACTIVE;
          run_n   = '0;
          fill_n  = '0;
          shreg_n = '0;
          cnt_n   = '0;
          do_proc = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.in_valid) begin
          do_proc = 1'b1;
        end else begin
          // Positions above fill are already zero, so the partial word needs no masking.
          eop_n   = 1'b1;
          ov_n    = (fill_q != '0);
          od_n    = (fill_q != '0) ? shreg_q : '0;
          on_n    = fill_q;
          fill_n  = '0;
          shreg_n = '0;
          run_n   = '0;
          state_n = IDLE;
        end
      end
      ERROR: begin
        if (!bus.in_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (do_proc) begin
      if (run_n == RUN_MAX && !bus.in_bit) begin
        run_n = '0;
      end else if (run_n == RUN_MAX && CHECK_ERR != 0) begin
        err_n   = 1'b1;
        run_n   = '0;
        fill_n  = '0;
        shreg_n = '0;
        state_n = ERROR;
      end else begin
        if (!bus.in_bit)          run_n = '0;
        else if (run_n == RUN_MAX) run_n = RUN_W'(1);
        else                       run_n = run_n + RUN_W'(1);

        word_n = shreg_n | (OUT_W'(bus.in_bit) << fill_n);
        if (cnt_n != '1) cnt_n = cnt_n + CNT_W'(1);

        if (fill_n == LAST_POS) begin
          ov_n    = 1'b1;
          od_n    = word_n;
          on_n    = FULL;
          fill_n  = '0;
          shreg_n = '0;
        end else begin
          shreg_n = word_n;
          fill_n  = fill_n + NB_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_nbits = on_q;
  assign bus.out_eop   = eop_q;
  assign bus.stuff_err = err_q;
  assign bus.bit_count = cnt_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bit_unstuffer_deser.sv
// Directed bench: default instance plus a CHECK_ERR=0 instance, outputs sampled 1 time unit after each edge.
module tb_bit_unstuffer_deser;
  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;

  bit_unstuffer_deser_if #(.OUT_W(8), .CNT_W(16)) bus_a ();
  bit_unstuffer_deser_if #(.OUT_W(8), .CNT_W(16)) bus_b ();

  bit_unstuffer_deser #(.OUT_W(8), .RUN_LEN(6), .CHECK_ERR(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
  );
  bit_unstuffer_deser #(.OUT_W(8), .RUN_LEN(6), .CHECK_ERR(0), .CNT_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic send_a(input logic b);
    bus_a.in_valid = 1'b1;
    bus_a.in_bit   = b;
    @(posedge clock); #1;
  endtask

  task automatic idle_a();
    bus_a.in_valid = 1'b0;
    bus_a.in_bit   = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic send_b(input logic b);
    bus_b.in_valid = 1'b1;
    bus_b.in_bit   = b;
    @(posedge clock); #1;
  endtask

  task automatic idle_b();
    bus_b.in_valid = 1'b0;
    bus_b.in_bit   = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_total++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.out_nbits, bus_a.out_eop, bus_a.stuff_err,
         bus_a.bit_count, bus_a.busy} !== 32'd0)
      $display("FAIL reset_a: outputs=%h expected all zero",
               {bus_a.out_valid, bus_a.out_data, bus_a.out_nbits, bus_a.out_eop,
                bus_a.stuff_err, bus_a.bit_count, bus_a.busy});
    else n_pass++;
    n_total++;
    if ({bus_b.out_valid, bus_b.out_data, bus_b.out_nbits, bus_b.out_eop, bus_b.stuff_err,
         bus_b.bit_count, bus_b.busy} !== 32'd0)
      $display("FAIL reset_b: outputs=%h expected all zero",
               {bus_b.out_valid, bus_b.out_data, bus_b.out_nbits, bus_b.out_eop,
                bus_b.stuff_err, bus_b.bit_count, bus_b.busy});
    else n_pass++;
    reset_n = 1'b1;
    idle_a();
  endtask

  task automatic test_stuff_removal();
    logic [8:0] bits;
    bits = 9'b100111111; // sent LSB first: 1,1,1,1,1,1,0,0,1
    for (int i = 0; i < 9; i++) send_a(bits[i]);
    n_total++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.out_nbits} !== {1'b1, 8'hBF, 4'd8})
      $display("FAIL stuff_word: v=%b data=%h nbits=%0d expected v=1 data=bf nbits=8",
               bus_a.out_valid, bus_a.out_data, bus_a.out_nbits);
    else n_pass++;
    idle_a();
    n_total++;
    if ({bus_a.out_eop, bus_a.out_valid} !== 2'b10)
      $display("FAIL stuff_eop: eop=%b v=%b expected eop=1 v=0", bus_a.out_eop, bus_a.out_valid);
    else n_pass++;
    n_total++;
    if (bus_a.bit_count !== 16'd8)
      $display("FAIL stuff_count: got %0d expected 8", bus_a.bit_count);
    else n_pass++;
    idle_a();
    n_total++;
    if (bus_a.bit_count !== 16'd8)
      $display("FAIL count_hold: got %0d expected 8", bus_a.bit_count);
    else n_pass++;
  endtask

  task automatic test_stuff_error();
    for (int i = 0; i < 7; i++) send_a(1'b1);
    n_total++;
    if ({bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy} !== 4'b1001)
      $display("FAIL err_pulse: err=%b v=%b eop=%b busy=%b expected 1,0,0,1",
               bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      send_a(1'b1);
      n_total++;
      if ({bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy} !== 4'b0001)
        $display("FAIL err_hold%0d: err=%b v=%b eop=%b busy=%b expected 0,0,0,1", i,
                 bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy);
      else n_pass++;
    end
    idle_a();
    n_total++;
    if ({bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy} !== 4'b0000)
      $display("FAIL err_exit: err=%b v=%b eop=%b busy=%b expected all 0",
               bus_a.stuff_err, bus_a.out_valid, bus_a.out_eop, bus_a.busy);
    else n_pass++;
    idle_a();
  endtask

  task automatic test_no_check();
    for (int i = 0; i < 8; i++) begin
      send_b(i < 7 ? 1'b1 : 1'b0);
      n_total++;
      if (bus_b.stuff_err !== 1'b0)
        $display("FAIL nochk_err%0d: got %b expected 0", i, bus_b.stuff_err);
      else n_pass++;
    end
    n_total++;
    if ({bus_b.out_valid, bus_b.out_data, bus_b.out_nbits} !== {1'b1, 8'h7F, 4'd8})
      $display("FAIL nochk_word: v=%b data=%h nbits=%0d expected v=1 data=7f nbits=8",
               bus_b.out_valid, bus_b.out_data, bus_b.out_nbits);
    else n_pass++;
    idle_b();
    n_total++;
    if ({bus_b.out_eop, bus_b.out_valid, bus_b.stuff_err} !== 3'b100)
      $display("FAIL nochk_eop: eop=%b v=%b err=%b expected 1,0,0",
               bus_b.out_eop, bus_b.out_valid, bus_b.stuff_err);
    else n_pass++;
    idle_b();
  endtask

  task automatic test_partial_flush();
    logic [11:0] bits;
    bits = 12'b0011_0101_0101; // 0x55 LSB first, then 1,1,0,0
    for (int i = 0; i < 8; i++) send_a(bits[i]);
    n_total++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.out_nbits} !== {1'b1, 8'h55, 4'd8})
      $display("FAIL part_word: v=%b data=%h nbits=%0d expected v=1 data=55 nbits=8",
               bus_a.out_valid, bus_a.out_data, bus_a.out_nbits);
    else n_pass++;
    for (int i = 8; i < 12; i++) send_a(bits[i]);
    n_total++;
    if (bus_a.out_valid !== 1'b0)
      $display("FAIL part_mid: v=%b expected 0", bus_a.out_valid);
    else n_pass++;
    idle_a();
    n_total++;
    if ({bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.bit_count}
        !== {1'b1, 1'b1, 8'h03, 4'd4, 16'd12})
      $display("FAIL part_flush: v=%b eop=%b data=%h nbits=%0d cnt=%0d expected 1,1,03,4,12",
               bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.bit_count);
    else n_pass++;
    idle_a();
  endtask

  task automatic test_run_at_end();
    for (int i = 0; i < 6; i++) send_a(1'b1);
    idle_a();
    n_total++;
    if ({bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.stuff_err}
        !== {1'b1, 1'b1, 8'h3F, 4'd6, 1'b0})
      $display("FAIL run_end: v=%b eop=%b data=%h nbits=%0d err=%b expected 1,1,3f,6,0",
               bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.stuff_err);
    else n_pass++;
    idle_a();
  endtask

  task automatic test_reset_mid_packet();
    logic [8:0] bits;
    for (int i = 0; i < 5; i++) send_a(1'b1);
    reset_n = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_bit   = 1'b1;
    @(posedge clock); #1;
    n_total++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.out_nbits, bus_a.out_eop, bus_a.stuff_err,
         bus_a.bit_count, bus_a.busy} !== 32'd0)
      $display("FAIL mid_reset: outputs=%h expected all zero",
               {bus_a.out_valid, bus_a.out_data, bus_a.out_nbits, bus_a.out_eop,
                bus_a.stuff_err, bus_a.bit_count, bus_a.busy});
    else n_pass++;
    reset_n = 1'b1;
    // Fresh run counter: six ones, stuff zero, then 1,0 -> 0x7F with no error.
    bits = 9'b010111111;
    for (int i = 0; i < 9; i++) begin
      send_a(bits[i]);
      if (i < 8) begin
        n_total++;
        if ({bus_a.stuff_err, bus_a.out_eop, bus_a.busy} !== 3'b001)
          $display("FAIL fresh_bit%0d: err=%b eop=%b busy=%b expected 0,0,1", i,
                   bus_a.stuff_err, bus_a.out_eop, bus_a.busy);
        else n_pass++;
      end
    end
    n_total++;
    if ({bus_a.out_valid, bus_a.out_data, bus_a.out_nbits} !== {1'b1, 8'h7F, 4'd8})
      $display("FAIL fresh_word: v=%b data=%h nbits=%0d expected v=1 data=7f nbits=8",
               bus_a.out_valid, bus_a.out_data, bus_a.out_nbits);
    else n_pass++;
    idle_a();
    n_total++;
    if ({bus_a.out_eop, bus_a.out_valid, bus_a.bit_count} !== {1'b1, 1'b0, 16'd8})
      $display("FAIL fresh_eop: eop=%b v=%b cnt=%0d expected 1,0,8",
               bus_a.out_eop, bus_a.out_valid, bus_a.bit_count);
    else n_pass++;
    idle_a();
  endtask

  task automatic test_single_bit();
    send_a(1'b1);
    idle_a();
    n_total++;
    if ({bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.bit_count}
        !== {1'b1, 1'b1, 8'h01, 4'd1, 16'd1})
      $display("FAIL single_bit: v=%b eop=%b data=%h nbits=%0d cnt=%0d expected 1,1,01,1,1",
               bus_a.out_valid, bus_a.out_eop, bus_a.out_data, bus_a.out_nbits, bus_a.bit_count);
    else n_pass++;
    idle_a();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stuff_removal();
    test_stuff_error();
    test_no_check();
    test_partial_flush();
    test_run_at_end();
    test_reset_mid_packet();
    test_single_bit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bit_unstuffer_deser.md
Name: bit_unstuffer_deser

Overview:
Parametrised successor to the receive-path bit-stuffing decoder. It sits between the NRZI decoder and the packet/PID parser. It removes stuffed zeros after a configurable run of ones and optionally flags stuffing violations. It also assembles the destuffed bitstream LSB-first into OUT_W-wide words with explicit end-of-packet and partial-word signalling, replacing the old tri-stated per-bit output.

Parameters:
OUT_W, 8, output word width in bits; legal range 1..32.
RUN_LEN, 6, number of consecutive ones after which the next bit is a stuff bit; must be >= 1.
CHECK_ERR, 1, 1 = a one arriving in the stuff position is a stuffing error; 0 = that bit is accepted as data.
CNT_W, 16, width of the per-packet destuffed bit counter.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
in_valid  input  1  upstream NRZI decoder is sending; a packet is a maximal run of cycles with in_valid=1.
in_bit  input  1  NRZI-decoded bit; sampled only when in_valid=1.
out_valid  output  1  one-cycle pulse; out_data/out_nbits are valid.
out_data  output  OUT_W  destuffed word; first received bit is in out_data[0]; unused upper bits are 0.
out_nbits  output  $clog2(OUT_W+1)  number of valid bits in out_data; OUT_W for a full word, 1..OUT_W-1 for a flushed partial word.
out_eop  output  1  one-cycle pulse marking the end of a packet that ended without error.
stuff_err  output  1  one-cycle pulse on a stuffing violation (CHECK_ERR=1 only).
bit_count  output  CNT_W  destuffed data bits in the current or most recent packet; saturates at all-ones.
busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0 at an edge): FSM to IDLE; run counter, shift register, fill count and bit_count cleared. All outputs are 0 in the following cycle.
  - Reset mid-packet drops all partial data and emits no out_eop.
  - If in_valid is still 1 after reset is released, the next sampled bit starts a new packet.
- FSM has three states:
  - IDLE: in_valid=0 -> stay. in_valid=1 -> new packet. Clear bit_count, run counter and fill, then process the bit as the first bit of the packet (a leading 1 counts toward the run). Go to ACTIVE.
  - ACTIVE: in_valid=1 -> process the bit and stay. in_valid=0 -> flush, then go to IDLE.
  - ERROR: discard all input. On in_valid=0 go to IDLE with no out_eop and no flush.
- Bit processing (ones run counter is $clog2(RUN_LEN+1) bits wide):
  - Counter < RUN_LEN, bit=1: the bit is data; counter increments.
  - Counter < RUN_LEN, bit=0: the bit is data; counter clears.
  - Counter == RUN_LEN, bit=0: this is the stuff bit; discard it, clear counter. No data shift, bit_count unchanged.
  - Counter == RUN_LEN, bit=1, CHECK_ERR=1: stuff_err=1 in the next cycle, partial word discarded, go to ERROR.
  - Counter == RUN_LEN, bit=1, CHECK_ERR=0: the bit is data; counter set to 1.
- Each data bit shifts into the word at position fill, then fill increments and bit_count increments (saturating at all-ones).
- Word completion: when fill reaches OUT_W, the cycle after the completing bit is sampled shows out_valid=1 and out_nbits=OUT_W. fill returns to 0. Latency is 1 cycle; there is no back-pressure.
- Flush: at the edge where ACTIVE samples in_valid=0, the next cycle shows out_eop=1.
  - fill > 0: out_valid=1 in the same cycle, with out_nbits=fill and upper bits zeroed.
  - fill = 0: out_valid=0.
  - A full word and a flush can never fall on the same cycle.
- A packet that ends right after a RUN_LEN run, before the stuff bit arrives, is not an error; flush as normal.
- bit_count holds its value after the packet ends until the next packet starts.
- A single-cycle in_valid pulse forms a one-bit packet.
- busy=1 in ACTIVE and ERROR.

Test Plan:
1. Stuff removal (defaults): 9 valid bits 1,1,1,1,1,1,0,0,1, then in_valid=0.
   - Required: out_valid with out_data=0xBF, out_nbits=8, one cycle after the 9th bit.
   - Next cycle: out_eop=1 with out_valid=0; bit_count=8.
2. Stuff error: seven 1s, then in_valid held high for 3 more cycles, then low.
   - Required: stuff_err pulse in the cycle after the 7th bit; no out_valid and no out_eop.
   - busy stays 1 until the cycle after in_valid falls.
3. CHECK_ERR=0, same seven 1s followed by a 0, then end.
   - Required: out_data=0x7F, out_nbits=8, then out_eop; stuff_err never asserted.
4. Partial flush: bits of 0x55 LSB-first, then 1,1,0,0, then end.
   - Required: word 0x55 with nbits=8.
   - Then one cycle with out_valid=1, out_eop=1, out_data=0x03, out_nbits=4; bit_count=12.
5. Run at packet end: six 1s, then in_valid=0.
   - Required: out_eop together with out_data=0x3F, out_nbits=6; no stuff_err.
6. Reset mid-packet: 5 bits sent, reset_n=0 for one edge while in_valid stays 1.
   - Required: all outputs 0 and no out_eop for the aborted packet.
   - The following bits decode as a fresh packet, with the run counter starting at 0.
